// File: rtl/shift_register_pkg.sv
// Shared default for the serial shift register depth.
package shift_register_pkg;

  localparam int DefaultN = 8;

endpackage

// File: rtl/shift_stage.sv
// One bit of the shift chain: a D flip-flop with synchronous active-high reset
// to a parameterised value.
module shift_stage #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = d_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/shift_register.sv
// Serial-in / serial-out shift register of N stages with a parallel view of all stages.
// sh_out is the registered output of the last stage; there is no enable.
module shift_register
  import shift_register_pkg::*;
#(
  parameter int N       = DefaultN,
  parameter bit RST_VAL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sh_in,
  output logic         sh_out,
  output logic [N-1:0] q
);

  if (N < 1) begin : g_bad_n
    $fatal(1, "shift_register: N must be >= 1");
  end

  logic [N-1:0] s;

  // Stage 0 takes the serial input; every later stage takes its predecessor.
  for (genvar i = 0; i < N; i++) begin : g_stage
    if (i == 0) begin : g_first
      shift_stage #(
        .RST_VAL(RST_VAL)
      ) u_stage (
        .clk(clk),
        .rst(rst),
        .d_i(sh_in),
        .q_o(s[0])
      );
    end else begin : g_chain
      shift_stage #(
        .RST_VAL(RST_VAL)
      ) u_stage (
        .clk(clk),
        .rst(rst),
        .d_i(s[i-1]),
        .q_o(s[i])
      );
    end
  end

  assign sh_out = s[N-1];
  assign q      = s;

endmodule

// File: tb/tb_shift_register.sv
// Bench for shift_register: three instances (N=10/RST_VAL=0, N=1, N=10/RST_VAL=1)
// share clk, rst and sh_in and are compared against a history-based model.
module tb_shift_register;

  logic clk = 1'b0;
  logic rst;
  logic sh_in;

  logic       a_out;
  logic [9:0] a_q;
  logic       b_out;
  logic [0:0] b_q;
  logic       c_out;
  logic [9:0] c_q;

  int checks = 0;
  int passes = 0;

  // Every value sampled on sh_in, indexed by edge number minus one.
  bit ins[$];
  int edge_n   = 0;
  int last_rst = 0;

  always #5 clk = ~clk;

  shift_register #(.N(10), .RST_VAL(1'b0)) u_a (
    .clk(clk), .rst(rst), .sh_in(sh_in), .sh_out(a_out), .q(a_q)
  );

  shift_register #(.N(1), .RST_VAL(1'b0)) u_b (
    .clk(clk), .rst(rst), .sh_in(sh_in), .sh_out(b_out), .q(b_q)
  );

  shift_register #(.N(10), .RST_VAL(1'b1)) u_c (
    .clk(clk), .rst(rst), .sh_in(sh_in), .sh_out(c_out), .q(c_q)
  );

  // Stage j after the latest edge k holds the bit sampled at edge k-j, unless that
  // edge is at or before the latest reset edge, in which case it holds the reset value.
  function automatic logic [9:0] exp_q(input int n, input bit rv);
    logic [9:0] v;
    v = '0;
    for (int j = 0; j < n; j++) begin
      if (edge_n - j > last_rst) v[j] = ins[edge_n - j - 1];
      else                       v[j] = rv;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] want);
    checks++;
    assert (got === want) begin
      passes++;
    end else begin
      $error("FAIL %s edge=%0d: got %b want %b", tag, edge_n, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    logic [9:0] ea;
    logic [9:0] eb;
    logic [9:0] ec;
    ea = exp_q(10, 1'b0);
    eb = exp_q(1, 1'b0);
    ec = exp_q(10, 1'b1);
    chk({tag, " a_out"}, {9'd0, a_out}, {9'd0, ea[9]});
    chk({tag, " a_q"}, a_q, ea);
    chk({tag, " b_out"}, {9'd0, b_out}, {9'd0, eb[0]});
    chk({tag, " b_q"}, {9'd0, b_q}, {9'd0, eb[0]});
    chk({tag, " c_out"}, {9'd0, c_out}, {9'd0, ec[9]});
    chk({tag, " c_q"}, c_q, ec);
  endtask

  task automatic step(input bit r, input bit d, input string tag);
    rst   = r;
    sh_in = d;
    @(posedge clk);
    edge_n++;
    ins.push_back(d);
    if (r) last_rst = edge_n;
    #1;
    check_all(tag);
  endtask

  int pulse_hits;
  int pulse_edge;
  int sample_edge;

  initial begin
    rst   = 1'b1;
    sh_in = 1'b0;
    #2;

    // Reset hold with sh_in toggling randomly.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), "rst_hold");
      chk("rst_hold a_q zero", a_q, 10'd0);
      chk("rst_hold c_q ones", c_q, 10'h3ff);
    end

    // Single pulse: one 1 then zeros; sh_out high for exactly one edge, 9 edges later.
    step(1'b0, 1'b1, "pulse_in");
    sample_edge = edge_n;
    pulse_hits  = 0;
    pulse_edge  = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b0, "pulse");
      if (a_out === 1'b1) begin
        pulse_hits++;
        pulse_edge = edge_n;
      end
    end
    chk("pulse count", pulse_hits[9:0], 10'd1);
    chk("pulse latency", 10'(pulse_edge - sample_edge), 10'd9);

    // Fill with ones then zeros.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, "fill1");
    chk("fill ones", a_q, 10'h3ff);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "fill0");
    chk("fill zeros", a_q, 10'd0);

    // Mid-stream reset discards in-flight ones.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, "ones");
    step(1'b1, 1'b1, "mid_rst");
    chk("mid_rst a_q", a_q, 10'd0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, "post_rst");
    chk("post_rst a_out", {9'd0, a_out}, 10'd1);

    // rst and sh_in changing between edges must not move the outputs.
    step(1'b0, 1'b0, "pre_async");
    rst   = 1'b1;
    sh_in = 1'b1;
    #2;
    check_all("async");

    // Long random stream: 200 cycles held in reset, then 800 free-running.
    for (int i = 0; i < 200; i++) step(1'b1, 1'($urandom_range(0, 1)), "rnd_rst");
    for (int i = 0; i < 800; i++) step(1'b0, 1'($urandom_range(0, 1)), "rnd");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
